onehot_decoder_seq: RTL and testbench

Parametrised registered binary-to-one-hot decoder, the successor to our fixed 3-to-8 combinational decoder. It adds an input valid/ready handshake, a registered output, and three operating modes: direct hold, timed pulse, and autonomous scan with programmable dwell. It drives one-hot enables such as row/channel selects, strobes and scanned displays from a single clock domain.

---
 rtl/onehot_decoder_pkg.sv | 29 ++
 rtl/onehot_decoder_seq_bin2onehot.sv | 14 +
 rtl/onehot_decoder_seq.sv | 116 +++++++++++
 tb/tb_onehot_decoder_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/onehot_decoder_pkg.sv
// Shared types and the binary-to-one-hot helper for the sequenced one-hot decoder.
package onehot_decoder_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_PULSE  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HOLD  = 2'b01,
        ST_PULSE = 2'b10,
        ST_SCAN  = 2'b11
    } state_e;

    // Full-width decode; callers size-cast the result down to their own OUT_W.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/onehot_decoder_seq_bin2onehot.sv
// Purely combinational SEL_W to 2**SEL_W one-hot decode.
module bin2onehot
    import onehot_decoder_pkg::*;
#(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 1 << SEL_W
) (
    input  logic [SEL_W-1:0] sel_i,
    output logic [OUT_W-1:0] onehot_o
);

    assign onehot_o = OUT_W'(onehot(MAX_SEL_W'(sel_i)));

endmodule

// File: rtl/onehot_decoder_seq.sv
// Registered one-hot decoder with valid/ready input and DIRECT / PULSE / SCAN modes.
module onehot_decoder_seq
    import onehot_decoder_pkg::*;
#(
    parameter  int SEL_W   = 3,
    parameter  int DWELL_W = 8,
    localparam int OUT_W   = 1 << SEL_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic               din_valid,
    output logic               din_ready,
    input  logic [SEL_W-1:0]   din,
    input  logic [DWELL_W-1:0] dwell,
    output logic [OUT_W-1:0]   dout,
    output logic [SEL_W-1:0]   idx,
    output logic               busy,
    output logic               wrap
);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               wrap_q, wrap_d;
    logic [OUT_W-1:0]   dec;
    mode_e              mode_m;
    logic               abort;
    logic               xfer;

    assign mode_m    = mode_e'(mode);
    assign abort     = !en || (mode_m == MODE_RSVD);
    assign din_ready = en && ((mode_m == MODE_DIRECT) || (mode_m == MODE_PULSE)) &&
                       ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign xfer      = din_valid && din_ready;

    // The decoder sees the next index so dout lands in the same register stage as idx.
    bin2onehot #(.SEL_W(SEL_W)) u_dec (
        .sel_i    (idx_d),
        .onehot_o (dec)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mode_m == MODE_SCAN) begin
                        state_d = ST_SCAN;
                        idx_d   = '0;
                        cnt_d   = dwell;
                    end else if (xfer) begin
                        state_d = (mode_m == MODE_PULSE) ? ST_PULSE : ST_HOLD;
                        idx_d   = din;
                        cnt_d   = dwell;
                    end
                end
                ST_HOLD: begin
                    if (mode_m != MODE_DIRECT) state_d = ST_IDLE;
                    else if (xfer)             idx_d   = din;
                end
                ST_PULSE: begin
                    if (mode_m != MODE_PULSE || cnt_q == '0) state_d = ST_IDLE;
                    else                                     cnt_d   = cnt_q - DWELL_W'(1);
                end
                ST_SCAN: begin
                    if (mode_m != MODE_SCAN) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == '0) begin
                        idx_d  = idx_q + SEL_W'(1);
                        cnt_d  = dwell;
                        wrap_d = (idx_q == '1);
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        if (state_d == ST_IDLE) begin
            idx_d = '0;
            cnt_d = '0;
        end
    end

    assign dout_d = (state_d == ST_IDLE) ? '0 : dec;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            wrap_q  <= wrap_d;
        end
    end

    assign dout = dout_q;
    assign idx  = idx_q;
    assign busy = (state_q == ST_PULSE) || (state_q == ST_SCAN);
    assign wrap = wrap_q;

endmodule

// File: tb/tb_onehot_decoder_seq.sv
// Bench for onehot_decoder_seq: directed scenarios plus random traffic against an activity-level model.
module tb_onehot_decoder_seq;

    localparam int SEL_W   = 3;
    localparam int DWELL_W = 8;
    localparam int OUT_W   = 1 << SEL_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, en, din_valid;
    logic [1:0]         mode;
    logic [SEL_W-1:0]   din;
    logic [DWELL_W-1:0] dwell;
    logic               din_ready, busy, wrap;
    logic [OUT_W-1:0]   dout;
    logic [SEL_W-1:0]   idx;

    logic       d1_din, d1_ready, d1_idx, d1_busy, d1_wrap;
    logic [1:0] d1_dout;
    logic [4:0] d5_din, d5_idx;
    logic       d5_ready, d5_busy, d5_wrap;
    logic [31:0] d5_dout;

    onehot_decoder_seq #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din_valid(din_valid),
        .din_ready(din_ready), .din(din), .dwell(dwell), .dout(dout), .idx(idx),
        .busy(busy), .wrap(wrap)
    );

    onehot_decoder_seq #(.SEL_W(1), .DWELL_W(DWELL_W)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din_valid(din_valid),
        .din_ready(d1_ready), .din(d1_din), .dwell(dwell), .dout(d1_dout), .idx(d1_idx),
        .busy(d1_busy), .wrap(d1_wrap)
    );

    onehot_decoder_seq #(.SEL_W(5), .DWELL_W(DWELL_W)) dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .din_valid(din_valid),
        .din_ready(d5_ready), .din(d5_din), .dwell(dwell), .dout(d5_dout), .idx(d5_idx),
        .busy(d5_busy), .wrap(d5_wrap)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // Model: what the block is doing (0 none, 1 hold, 2 pulse, 3 scan), which index, cycles left to show.
    int m_act  = 0;
    int m_idx  = 0;
    int m_left = 0;
    bit m_wrap = 0;

    function automatic logic [31:0] exp_dout();
        return (m_act == 0) ? 32'd0 : (32'd1 << m_idx);
    endfunction

    function automatic logic [31:0] exp_ready();
        return {31'd0, en && (mode < 2'd2) && (m_act <= 1)};
    endfunction

    task automatic model_step();
        bit abort;
        abort  = !en || (mode == 2'b11);
        m_wrap = 0;
        if (!rst_n) begin
            m_act = 0;
            m_idx = 0;
        end else if (m_act != 0 && (abort || int'(mode) != m_act - 1)) begin
            m_act = 0;
        end else begin
            case (m_act)
                0: if (!abort) begin
                    if (mode == 2'b10) begin
                        m_act = 3; m_idx = 0; m_left = int'(dwell) + 1;
                    end else if (din_valid) begin
                        m_act = (mode == 2'b00) ? 1 : 2; m_idx = int'(din); m_left = int'(dwell) + 1;
                    end
                end
                1: if (din_valid) m_idx = int'(din);
                2: begin
                    m_left--;
                    if (m_left == 0) m_act = 0;
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_idx  = (m_idx + 1) % OUT_W;
                        m_wrap = (m_idx == 0);
                        m_left = int'(dwell) + 1;
                    end
                end
            endcase
        end
    endtask

    task automatic tick();
        #1;
        chk("ready", {31'd0, din_ready}, exp_ready());
        @(posedge clk);
        model_step();
        #1;
        chk("dout", {24'd0, dout}, exp_dout());
        chk("busy", {31'd0, busy}, {31'd0, m_act >= 2});
        chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
        chk("onehot", {31'd0, $onehot0(dout)}, 32'd1);
        if (m_act != 0) chk("idx", {29'd0, idx}, m_idx);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'b00; din_valid = 1'b0;
        din = '0; dwell = '0; d1_din = 1'b0; d5_din = '0;
        tick(); tick();
        chk("rst_dout", {24'd0, dout}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // DIRECT: single transfer then back-to-back
        en = 1'b1; mode = 2'b00; din_valid = 1'b1; din = 3'd5;
        tick(); chk("direct5", {24'd0, dout}, 32'h20);
        din = 3'd0; tick(); chk("b2b0", {24'd0, dout}, 32'h01);
        din = 3'd7; tick(); chk("b2b7", {24'd0, dout}, 32'h80);
        din = 3'd3; tick(); chk("b2b3", {24'd0, dout}, 32'h08);
        din_valid = 1'b0; tick(); chk("hold3", {24'd0, dout}, 32'h08);

        // PULSE dwell=2
        mode = 2'b01; tick(); chk("to_idle", {24'd0, dout}, 32'h00);
        din_valid = 1'b1; din = 3'd6; dwell = 8'd2;
        tick(); chk("pulse0", {24'd0, dout}, 32'h40);
        din = 3'd1;
        for (int k = 1; k < 3; k++) begin
            tick();
            chk("pulseN", {24'd0, dout}, 32'h40);
            chk("pulse_busy", {31'd0, busy}, 32'd1);
        end
        din_valid = 1'b0;
        tick(); chk("pulse_end", {24'd0, dout}, 32'h00);

        // SCAN dwell=1
        mode = 2'b10; dwell = 8'd1;
        for (int k = 0; k <= 16; k++) begin
            tick();
            chk("scan", {24'd0, dout}, 32'd1 << ((k / 2) % 8));
            chk("scan_wrap", {31'd0, wrap}, {31'd0, k == 16});
        end

        // abort mid-dwell, then restart
        dwell = 8'd3; tick(); tick();
        en = 1'b0; tick();
        chk("abort_dout", {24'd0, dout}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        en = 1'b1; tick();
        chk("restart_dout", {24'd0, dout}, 32'h01);
        chk("restart_idx", {29'd0, idx}, 32'd0);

        // reset mid-pulse
        en = 1'b0; tick();
        en = 1'b1; mode = 2'b01; din_valid = 1'b1; din = 3'd4; dwell = 8'd5; tick();
        din_valid = 1'b0; tick();
        rst_n = 1'b0; tick();
        chk("rstmid_dout", {24'd0, dout}, 32'd0);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;

        // reserved mode ignores valid data
        mode = 2'b11; din_valid = 1'b1; din = 3'd2; tick();
        chk("rsvd_dout", {24'd0, dout}, 32'd0);
        chk("rsvd_ready", {31'd0, din_ready}, 32'd0);

        // random traffic
        mode = 2'b00;
        for (int c = 0; c < 1500; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            en        = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
            din_valid = 1'($urandom);
            din       = SEL_W'($urandom);
            dwell     = DWELL_W'($urandom_range(0, 3));
            tick();
        end

        // DIRECT sweep on all three widths
        rst_n = 1'b1; en = 1'b0; din_valid = 1'b0; tick();
        en = 1'b1; mode = 2'b00; din_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            din    = SEL_W'(i);
            d1_din = 1'(i);
            d5_din = 5'(i);
            tick();
            chk("w1_dout", {30'd0, d1_dout}, 32'd1 << (i % 2));
            chk("w1_idx", {31'd0, d1_idx}, i % 2);
            chk("w1_oh", {31'd0, $onehot(d1_dout)}, 32'd1);
            chk("w1_ctl", {29'd0, d1_ready, d1_busy, d1_wrap}, 32'b100);
            chk("w5_dout", d5_dout, 32'd1 << i);
            chk("w5_idx", {27'd0, d5_idx}, i);
            chk("w5_oh", {31'd0, $onehot(d5_dout)}, 32'd1);
            chk("w5_ctl", {29'd0, d5_ready, d5_busy, d5_wrap}, 32'b100);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
